stopwatch_bcd_core: RTL

Timekeeping stage directly upstream of the 7-segment digit multiplexer. Divides the system clock into 10 ms ticks and accumulates elapsed time as four packed BCD digits (SS.cc, 00.00 to 59.99). Controlled by start/stop, lap and clear button levels, which arrive already debounced. Output `number` connects straight to the multiplexer's packed-nybble input, with digit 0 (hundredths) in bits [3:0].

---
 rtl/stopwatch_bcd_core.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/stopwatch_bcd_core.sv
// stopwatch_bcd_core
//   Divides clk into 10 ms ticks and accumulates elapsed time as four
//   packed BCD digits (SS.cc, 00.00 .. 59.99). Button levels arrive already
//   debounced; each acts on its rising edge.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   start_stop  debounced level, rising edge toggles run/pause
//   lap         debounced level, rising edge enters/leaves lap freeze
//   clear       debounced level, rising edge clears from PAUSED
//   number      registered packed BCD {sec_tens, sec_ones, tenths, hundredths}
//   running     high in RUN or LAP
//   lap_active  high in LAP (display frozen on the latched value)
//   rollover    one-cycle pulse when 59.99 wraps to 00.00
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | cleared, prescaler and digits held at zero
// RUN    | counting, display shows live digits
// LAP    | counting, display shows the lap latch
// PAUSED | counting suspended, partial tick kept in the prescaler

module stopwatch_bcd_core #(
    parameter int TICK_DIV         = 1000000,
    parameter int NUMBER_OF_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_stop,
    input  logic                          lap,
    input  logic                          clear,
    output logic [4*NUMBER_OF_DIGITS-1:0] number,
    output logic                          running,
    output logic                          lap_active,
    output logic                          rollover
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        LAP    = 2'd2,
        PAUSED = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [3:0]    d0, d1, d2, d3;
    logic [15:0]   lap_latch;
    logic          ss_q, lap_q, clr_q;

    logic          ss_e, lap_e, clr_e;
    logic          counting, tick;
    logic [3:0]    n0, n1, n2, n3;
    logic          wrap;
    logic [15:0]   live;

    assign ss_e  = start_stop & ~ss_q;
    assign lap_e = lap & ~lap_q;
    assign clr_e = clear & ~clr_q;

    assign counting = (state == RUN) || (state == LAP);
    assign tick     = counting && (presc == PRESC_MAX);
    assign live     = {d3, d2, d1, d0};

    // Ripple BCD increment; sec_tens wraps at 5 to give a 60 s range.
    always_comb begin
        n0   = d0 + 4'd1;
        n1   = d1;
        n2   = d2;
        n3   = d3;
        wrap = 1'b0;
        if (d0 == 4'd9) begin
            n0 = 4'd0;
            n1 = d1 + 4'd1;
            if (d1 == 4'd9) begin
                n1 = 4'd0;
                n2 = d2 + 4'd1;
                if (d2 == 4'd9) begin
                    n2 = 4'd0;
                    n3 = d3 + 4'd1;
                    if (d3 == 4'd5) begin
                        n3   = 4'd0;
                        wrap = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            presc     <= '0;
            d0        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            lap_latch <= '0;
            ss_q      <= 1'b0;
            lap_q     <= 1'b0;
            clr_q     <= 1'b0;
            number    <= '0;
            rollover  <= 1'b0;
        end else begin
            ss_q     <= start_stop;
            lap_q    <= lap;
            clr_q    <= clear;
            rollover <= 1'b0;
            number   <= (state == LAP) ? lap_latch : live;

            // A tick always lands, even on the edge that leaves RUN/LAP.
            if (counting) begin
                if (tick) begin
                    presc    <= '0;
                    d0       <= n0;
                    d1       <= n1;
                    d2       <= n2;
                    d3       <= n3;
                    rollover <= wrap;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            case (state)
                IDLE: begin
                    presc <= '0;
                    if (ss_e) state <= RUN;
                end
                RUN: begin
                    if (ss_e) begin
                        state <= PAUSED;
                    end else if (lap_e) begin
                        state     <= LAP;
                        lap_latch <= live;  // pre-increment value on a coincident tick
                    end
                end
                LAP: begin
                    if (ss_e)       state <= PAUSED;
                    else if (lap_e) state <= RUN;
                end
                PAUSED: begin
                    if (clr_e) begin
                        state <= IDLE;
                        presc <= '0;
                        d0    <= '0;
                        d1    <= '0;
                        d2    <= '0;
                        d3    <= '0;
                    end else if (ss_e) begin
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running    = counting;
    assign lap_active = (state == LAP);

endmodule
